// File: rtl/cp0_ctrl_v2.sv
// CP0 coprocessor register block: BadVAddr, Count, Compare, Status, Cause, EPC.
// Resolves simultaneous exception causes, synchronises the external interrupt lines,
// runs the divided Count timer and supplies interrupt request, EPC and exception vector.
module cp0_ctrl_v2 #(
    parameter int unsigned HW_INT_NUM  = 6,
    parameter int unsigned TIMER_DIV   = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] BEV_VEC     = 32'hBFC00380,
    parameter logic [31:0] NORM_VEC    = 32'h80000180
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            cp0_addr,
    input  logic                  cp0_wen,
    input  logic [31:0]           cp0_wdata,
    output logic [31:0]           cp0_rdata,
    input  logic [7:0]            exc_vec,
    input  logic [31:0]           exc_pc,
    input  logic                  is_slot,
    input  logic [31:0]           bad_vaddr,
    input  logic                  eret,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic                  int_happen,
    output logic [31:0]           exc_target,
    output logic [31:0]           epc,
    output logic                  timer_int
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam int unsigned DIV_W  = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam int unsigned HW_LOW = (HW_INT_NUM < 5) ? HW_INT_NUM : 5;
    localparam logic        STATUS_BEV = 1'b1;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } exc_code_e;

    // architectural state
    logic [31:0]      badvaddr_q;
    logic [31:0]      count_q;
    logic [31:0]      compare_q;
    logic [31:0]      epc_q;
    logic [7:0]       im_q;
    logic             exl_q;
    logic             ie_q;
    logic             bd_q;
    logic             ti_q;
    logic [1:0]       ip_sw_q;
    logic [4:0]       exccode_q;
    logic [DIV_W-1:0] div_q;
    logic [SYNC_STAGES-1:0][HW_INT_NUM-1:0] sync_q;

    // derived signals
    logic [HW_INT_NUM-1:0] hw_synced;
    logic [4:0]            hw_low;
    logic [7:0]            ip;
    logic                  sel_ok;
    logic                  wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic                  exc_any;
    exc_code_e             win_code;
    logic                  upd_bad;
    logic [31:0]           bad_src;
    logic                  tick;
    logic [31:0]           count_inc;
    logic [31:0]           status_rd;
    logic [31:0]           cause_rd;

    assign sel_ok     = (cp0_addr[2:0] == 3'd0);
    assign wr_count   = cp0_wen & sel_ok & (cp0_addr[7:3] == REG_COUNT);
    assign wr_compare = cp0_wen & sel_ok & (cp0_addr[7:3] == REG_COMPARE);
    assign wr_status  = cp0_wen & sel_ok & (cp0_addr[7:3] == REG_STATUS);
    assign wr_cause   = cp0_wen & sel_ok & (cp0_addr[7:3] == REG_CAUSE);
    assign wr_epc     = cp0_wen & sel_ok & (cp0_addr[7:3] == REG_EPC);

    assign exc_any   = |exc_vec;
    assign tick      = (div_q == DIV_W'(TIMER_DIV - 1));
    assign count_inc = count_q + 32'd1;
    assign hw_synced = sync_q[SYNC_STAGES-1];

    assign status_rd = {9'b0, STATUS_BEV, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_rd  = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};

    assign int_happen = ie_q & ~exl_q & (|(im_q & ip));
    assign exc_target = STATUS_BEV ? BEV_VEC : NORM_VEC;
    assign epc        = epc_q;
    assign timer_int  = ti_q;

    // shift each hw_int line through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], hw_int};
        end
    end

    // assemble Cause.IP from software bits, synchronised lines and the timer
    always_comb begin
        hw_low = '0;
        hw_low[HW_LOW-1:0] = hw_synced[HW_LOW-1:0];
        ip = '0;
        ip[1:0] = ip_sw_q;
        ip[6:2] = hw_low;
        ip[7]   = ti_q | ((HW_INT_NUM == 6) ? hw_synced[HW_INT_NUM-1] : 1'b0);
    end

    // pick the highest-priority raised cause and its BadVAddr source
    always_comb begin
        win_code = EXC_INT;
        upd_bad  = 1'b0;
        bad_src  = '0;
        if (exc_vec[7]) begin
            win_code = EXC_INT;
        end else if (exc_vec[6]) begin
            win_code = EXC_ADEL;
            upd_bad  = 1'b1;
            bad_src  = exc_pc;
        end else if (exc_vec[5]) begin
            win_code = EXC_RI;
        end else if (exc_vec[4]) begin
            win_code = EXC_OV;
        end else if (exc_vec[3]) begin
            win_code = EXC_SYS;
        end else if (exc_vec[2]) begin
            win_code = EXC_BP;
        end else if (exc_vec[1]) begin
            win_code = EXC_ADEL;
            upd_bad  = 1'b1;
            bad_src  = bad_vaddr;
        end else if (exc_vec[0]) begin
            win_code = EXC_ADES;
            upd_bad  = 1'b1;
            bad_src  = bad_vaddr;
        end
    end

    // Status/Cause/EPC/BadVAddr update: exception beats eret beats mtc0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
        end else if (exc_any) begin
            exccode_q <= win_code;
            exl_q     <= 1'b1;
            if (!exl_q) begin
                epc_q <= is_slot ? (exc_pc - 32'd4) : exc_pc;
                bd_q  <= is_slot;
            end
            if (upd_bad) begin
                badvaddr_q <= bad_src;
            end
        end else begin
            if (wr_status) begin
                im_q  <= cp0_wdata[15:8];
                exl_q <= cp0_wdata[1];
                ie_q  <= cp0_wdata[0];
            end
            // placed after the Status write so eret owns EXL when both occur
            if (eret) begin
                exl_q <= 1'b0;
            end
            if (wr_cause) begin
                ip_sw_q <= cp0_wdata[9:8];
            end
            if (wr_epc) begin
                epc_q <= cp0_wdata;
            end
        end
    end

    // divided Count timer, Compare register and sticky timer interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            div_q     <= '0;
            ti_q      <= 1'b0;
        end else begin
            if (wr_count) begin
                count_q <= cp0_wdata;
                div_q   <= '0;
            end else if (tick) begin
                count_q <= count_inc;
                div_q   <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (wr_compare) begin
                compare_q <= cp0_wdata;
            end
            if (wr_compare) begin
                ti_q <= 1'b0;
            end else if (!wr_count && tick && (count_inc == compare_q)) begin
                ti_q <= 1'b1;
            end
        end
    end

    // mfc0 read mux
    always_comb begin
        cp0_rdata = '0;
        if (sel_ok) begin
            case (cp0_addr[7:3])
                REG_BADVADDR: cp0_rdata = badvaddr_q;
                REG_COUNT:    cp0_rdata = count_q;
                REG_COMPARE:  cp0_rdata = compare_q;
                REG_STATUS:   cp0_rdata = status_rd;
                REG_CAUSE:    cp0_rdata = cause_rd;
                REG_EPC:      cp0_rdata = epc_q;
                default:      cp0_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_ctrl_v2.sv
// Directed bench for cp0_ctrl_v2 with default parameters.
module tb_cp0_ctrl_v2;

    localparam logic [7:0] A_BADV = 8'h40;
    localparam logic [7:0] A_CNT  = 8'h48;
    localparam logic [7:0] A_CMP  = 8'h58;
    localparam logic [7:0] A_STAT = 8'h60;
    localparam logic [7:0] A_CAUS = 8'h68;
    localparam logic [7:0] A_EPC  = 8'h70;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cp0_addr = '0;
    logic        cp0_wen = 1'b0;
    logic [31:0] cp0_wdata = '0;
    logic [31:0] cp0_rdata;
    logic [7:0]  exc_vec = '0;
    logic [31:0] exc_pc = '0;
    logic        is_slot = 1'b0;
    logic [31:0] bad_vaddr = '0;
    logic        eret = 1'b0;
    logic [5:0]  hw_int = '0;
    logic        int_happen;
    logic [31:0] exc_target;
    logic [31:0] epc;
    logic        timer_int;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] d;

    cp0_ctrl_v2 #(
        .HW_INT_NUM(6),
        .TIMER_DIV(2),
        .SYNC_STAGES(2),
        .BEV_VEC(32'hBFC00380),
        .NORM_VEC(32'h80000180)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cp0_addr(cp0_addr), .cp0_wen(cp0_wen), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .exc_vec(exc_vec), .exc_pc(exc_pc), .is_slot(is_slot), .bad_vaddr(bad_vaddr),
        .eret(eret), .hw_int(hw_int),
        .int_happen(int_happen), .exc_target(exc_target), .epc(epc), .timer_int(timer_int)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] v);
        cp0_addr = a;
        cp0_wdata = v;
        cp0_wen = 1'b1;
        step();
        cp0_wen = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        cp0_addr = a;
        #1;
        v = cp0_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        rd(A_STAT, d); n_checks++; if (d !== 32'h00400000) begin n_fail++; $display("FAIL reset_status: got %h expected %h", d, 32'h00400000); end
        rd(A_CAUS, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_cause: got %h expected 0", d); end
        rd(A_EPC, d);  n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h expected 0", d); end
        rd(A_CNT, d);  n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", d); end
        n_checks++; if (exc_target !== 32'hBFC00380) begin n_fail++; $display("FAIL reset_exc_target: got %h expected bfc00380", exc_target); end
        n_checks++; if ({int_happen, timer_int} !== 2'b00) begin n_fail++; $display("FAIL reset_irq: got %b expected 00", {int_happen, timer_int}); end
        n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc_port: got %h expected 0", epc); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_exception();
        bad_vaddr = 32'hDEADBEEF;
        exc_vec = 8'h21; exc_pc = 32'h80001000; is_slot = 1'b1;
        step();
        exc_vec = '0; is_slot = 1'b0;
        rd(A_CAUS, d); n_checks++; if (d !== 32'h80000028) begin n_fail++; $display("FAIL exc1_cause: got %h expected 80000028", d); end
        rd(A_STAT, d); n_checks++; if (d !== 32'h00400002) begin n_fail++; $display("FAIL exc1_status: got %h expected 00400002", d); end
        rd(A_EPC, d);  n_checks++; if (d !== 32'h80000FFC) begin n_fail++; $display("FAIL exc1_epc: got %h expected 80000ffc", d); end
        n_checks++; if (epc !== 32'h80000FFC) begin n_fail++; $display("FAIL exc1_epc_port: got %h expected 80000ffc", epc); end
        rd(A_BADV, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL exc1_badvaddr: got %h expected 0", d); end
        exc_vec = 8'h08; exc_pc = 32'h80002000;
        step();
        exc_vec = '0;
        rd(A_CAUS, d); n_checks++; if (d !== 32'h80000020) begin n_fail++; $display("FAIL exc2_cause: got %h expected 80000020", d); end
        rd(A_EPC, d);  n_checks++; if (d !== 32'h80000FFC) begin n_fail++; $display("FAIL exc2_epc_hold: got %h expected 80000ffc", d); end
        eret = 1'b1;
        step();
        eret = 1'b0;
        rd(A_STAT, d); n_checks++; if (d !== 32'h00400000) begin n_fail++; $display("FAIL eret_status: got %h expected 00400000", d); end
        rd(A_CAUS, d); n_checks++; if (d !== 32'h80000020) begin n_fail++; $display("FAIL eret_cause: got %h expected 80000020", d); end
    endtask

    task automatic test_timer();
        mtc0(A_STAT, 32'h0000FC01);
        rd(A_STAT, d); n_checks++; if (d !== 32'h0040FC01) begin n_fail++; $display("FAIL timer_status_wr: got %h expected 0040fc01", d); end
        mtc0(A_CMP, 32'd3);
        mtc0(A_CNT, 32'd0);
        repeat (5) step();
        rd(A_CNT, d); n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL timer_count5: got %h expected 2", d); end
        n_checks++; if ({timer_int, int_happen} !== 2'b00) begin n_fail++; $display("FAIL timer_before: got %b expected 00", {timer_int, int_happen}); end
        step();
        n_checks++; if ({timer_int, int_happen} !== 2'b11) begin n_fail++; $display("FAIL timer_fire: got %b expected 11", {timer_int, int_happen}); end
        rd(A_CAUS, d); n_checks++; if (d !== 32'hC0008020) begin n_fail++; $display("FAIL timer_cause: got %h expected c0008020", d); end
        mtc0(A_CMP, 32'h100);
        n_checks++; if ({timer_int, int_happen} !== 2'b00) begin n_fail++; $display("FAIL timer_clear: got %b expected 00", {timer_int, int_happen}); end
    endtask

    task automatic test_hwint();
        hw_int = 6'b000001;
        step();
        n_checks++; if (int_happen !== 1'b0) begin n_fail++; $display("FAIL hwint_early: got %b expected 0", int_happen); end
        step();
        n_checks++; if (int_happen !== 1'b1) begin n_fail++; $display("FAIL hwint_rise: got %b expected 1", int_happen); end
        rd(A_CAUS, d); n_checks++; if (d !== 32'h80000420) begin n_fail++; $display("FAIL hwint_cause: got %h expected 80000420", d); end
        step();
        hw_int = '0;
        step(); step();
        n_checks++; if (int_happen !== 1'b0) begin n_fail++; $display("FAIL hwint_fall: got %b expected 0", int_happen); end
        mtc0(A_CNT, 32'hFFFFFFFF);
        step();
        rd(A_CNT, d); n_checks++; if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wrap_hold: got %h expected ffffffff", d); end
        step();
        rd(A_CNT, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0", d); end
        n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL wrap_ti: got %b expected 0", timer_int); end
    endtask

    task automatic test_exc_mtc0_conflict();
        mtc0(A_STAT, 32'h0);
        cp0_addr = A_STAT; cp0_wdata = 32'h1; cp0_wen = 1'b1;
        exc_vec = 8'h40; exc_pc = 32'h00000003; is_slot = 1'b0;
        step();
        cp0_wen = 1'b0; exc_vec = '0;
        rd(A_STAT, d); n_checks++; if (d !== 32'h00400002) begin n_fail++; $display("FAIL conflict_status: got %h expected 00400002", d); end
        rd(A_BADV, d); n_checks++; if (d !== 32'h00000003) begin n_fail++; $display("FAIL conflict_badvaddr: got %h expected 3", d); end
        rd(A_CAUS, d); n_checks++; if (d !== 32'h00000010) begin n_fail++; $display("FAIL conflict_cause: got %h expected 10", d); end
        rd(A_EPC, d);  n_checks++; if (d !== 32'h00000003) begin n_fail++; $display("FAIL conflict_epc: got %h expected 3", d); end
    endtask

    task automatic test_back_to_back();
        eret = 1'b1; exc_vec = 8'h04;
        step();
        eret = 1'b0;
        exc_vec = 8'h02; bad_vaddr = 32'h12345678;
        rd(A_STAT, d); n_checks++; if (d !== 32'h00400002) begin n_fail++; $display("FAIL b2b_eret_vs_exc: got %h expected 00400002", d); end
        rd(A_CAUS, d); n_checks++; if (d !== 32'h00000024) begin n_fail++; $display("FAIL b2b_bp_cause: got %h expected 24", d); end
        step();
        exc_vec = 8'h10;
        rd(A_BADV, d); n_checks++; if (d !== 32'h12345678) begin n_fail++; $display("FAIL b2b_adeld_badv: got %h expected 12345678", d); end
        rd(A_CAUS, d); n_checks++; if (d !== 32'h00000010) begin n_fail++; $display("FAIL b2b_adeld_cause: got %h expected 10", d); end
        step();
        exc_vec = '0;
        rd(A_CAUS, d); n_checks++; if (d !== 32'h00000030) begin n_fail++; $display("FAIL b2b_ov_cause: got %h expected 30", d); end
        rd(A_EPC, d);  n_checks++; if (d !== 32'h00000003) begin n_fail++; $display("FAIL b2b_epc_hold: got %h expected 3", d); end
        eret = 1'b1;
        step();
        eret = 1'b0;
        rd(A_STAT, d); n_checks++; if (d !== 32'h00400000) begin n_fail++; $display("FAIL b2b_eret: got %h expected 00400000", d); end
    endtask

    task automatic test_addr_map();
        mtc0(A_CAUS, 32'hFFFFFFFF);
        rd(A_CAUS, d); n_checks++; if (d !== 32'h00000330) begin n_fail++; $display("FAIL map_cause_wr: got %h expected 330", d); end
        mtc0(8'h61, 32'h0000FFFF);
        rd(A_STAT, d); n_checks++; if (d !== 32'h00400000) begin n_fail++; $display("FAIL map_sel_wr: got %h expected 00400000", d); end
        rd(8'h61, d);  n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL map_sel_rd: got %h expected 0", d); end
        rd(8'hFF, d);  n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL map_bad_rd: got %h expected 0", d); end
        mtc0(A_BADV, 32'h0);
        rd(A_BADV, d); n_checks++; if (d !== 32'h12345678) begin n_fail++; $display("FAIL map_badv_ro: got %h expected 12345678", d); end
        mtc0(A_EPC, 32'hA0000000);
        rd(A_EPC, d);  n_checks++; if (d !== 32'hA0000000) begin n_fail++; $display("FAIL map_epc_wr: got %h expected a0000000", d); end
        n_checks++; if (epc !== 32'hA0000000) begin n_fail++; $display("FAIL map_epc_port: got %h expected a0000000", epc); end
    endtask

    task automatic test_reset_midop();
        exc_vec = 8'h80; exc_pc = 32'h55;
        #2 rst_n = 1'b0;
        #1;
        rd(A_STAT, d); n_checks++; if (d !== 32'h00400000) begin n_fail++; $display("FAIL midrst_status: got %h expected 00400000", d); end
        rd(A_CAUS, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_cause: got %h expected 0", d); end
        rd(A_BADV, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_badv: got %h expected 0", d); end
        n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL midrst_epc: got %h expected 0", epc); end
        step();
        exc_vec = '0;
        rst_n = 1'b1;
        step();
        rd(A_STAT, d); n_checks++; if (d !== 32'h00400000) begin n_fail++; $display("FAIL midrst_release: got %h expected 00400000", d); end
        rd(A_EPC, d);  n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_epc_after: got %h expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_exception();
        test_timer();
        test_hwint();
        test_exc_mtc0_conflict();
        test_back_to_back();
        test_addr_map();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
